fma_pass_sched: RTL and testbench

Job scheduler for the multi-precision posit FMA datapath. Accepts FMA jobs on a valid/ready request port and queues them in a small FIFO. For each job it launches the datapath with a one-cycle `start` and waits out the pipeline latency. It then sequences the lane-merge passes that raise the result from the input precision to the output precision, driving `align_ctl` and the current merge precision. It returns a tagged completion on a valid/ready done port.

---
 rtl/fma_pkg.sv | 37 +++
 rtl/fma_job_fifo.sv | 63 ++++++
 rtl/fma_pass_sched.sv | 192 +++++++++++++++++++
 tb/tb_fma_pass_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared types and helpers for the posit FMA pass scheduler
//
// Contents:
//   PRE_4X/PRE_2X/PRE_1X/PRE_BAD : lane precision codes
//   sched_state_e                : scheduler FSM states
//   job_t                        : queued job {in_pre, out_pre, tag}
//   pre_legal()                  : legality check for a precision pair
package fma_pkg;

  localparam logic [1:0] PRE_4X  = 2'b00;
  localparam logic [1:0] PRE_2X  = 2'b01;
  localparam logic [1:0] PRE_1X  = 2'b10;
  localparam logic [1:0] PRE_BAD = 2'b11;

  localparam int JOB_TAG_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_MERGE,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    logic [1:0]           in_pre;
    logic [1:0]           out_pre;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;

  // Merging only ever widens lanes, so the result may not be narrower
  // than the operands.
  function automatic logic pre_legal(input logic [1:0] in_p, input logic [1:0] out_p);
    return (in_p != PRE_BAD) && (out_p != PRE_BAD) && (out_p >= in_p);
  endfunction

endpackage

// File: rtl/fma_job_fifo.sv
// rtl/fma_job_fifo.sv - synchronous job queue for the FMA pass scheduler
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_data_i (ignored while full)
//   push_data_i    : job to enqueue
//   pop_i          : drop the head entry (ignored while empty)
//   head_o         : current head entry, valid while !empty_o
//   full_o/empty_o : occupancy flags
module fma_job_fifo
  import fma_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = job_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  T               mem_q [DEPTH];
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/fma_pass_sched.sv
// rtl/fma_pass_sched.sv - job scheduler for the multi-precision posit FMA datapath
//
// Queues FMA jobs, launches the datapath, waits out its latency, sequences
// the lane-merge passes from in_pre up to out_pre, and reports a tagged
// completion.
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/req_ready                : job request handshake
//   req_in_pre/req_out_pre/req_tag     : job fields
//   start                              : one-cycle datapath launch
//   in_pre/out_pre                     : launched job's precisions (held)
//   align_ctl/merge_pre                : merge pass active / precision merged from
//   busy                               : scheduler not idle
//   done_valid/done_ready              : completion handshake
//   done_tag/done_err                  : completed tag / job was illegal
//   perf_jobs/perf_merges              : only with FMA_SCHED_PERF_EN defined
//
// Optional feature macro: FMA_SCHED_PERF_EN (saturating job/merge counters).
module fma_pass_sched
  import fma_pkg::*;
#(
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_in_pre,
  input  logic [1:0]       req_out_pre,
  input  logic [TAG_W-1:0] req_tag,
  output logic             start,
  output logic [1:0]       in_pre,
  output logic [1:0]       out_pre,
  output logic             align_ctl,
  output logic [1:0]       merge_pre,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [TAG_W-1:0] done_tag,
  output logic             done_err
`ifdef FMA_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_jobs,
  output logic [15:0]      perf_merges
`endif
);

  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);

  typedef struct packed {
    logic [1:0]       in_pre;
    logic [1:0]       out_pre;
    logic [TAG_W-1:0] tag;
  } sched_job_t;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_pre_q, cur_pre_d;
  logic [1:0]       in_pre_q, in_pre_d;
  logic [1:0]       out_pre_q, out_pre_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  sched_job_t       fifo_in, fifo_head;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign fifo_in   = '{in_pre: req_in_pre, out_pre: req_out_pre, tag: req_tag};
  assign req_ready = !fifo_full;

  fma_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sched_job_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_valid),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_pre_q <= '0;
      in_pre_q  <= '0;
      out_pre_q <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_pre_q <= cur_pre_d;
      in_pre_q  <= in_pre_d;
      out_pre_q <= out_pre_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_pre_d = cur_pre_q;
    in_pre_d  = in_pre_q;
    out_pre_d = out_pre_q;
    tag_d     = tag_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tag_d    = fifo_head.tag;
          err_d    = !pre_legal(fifo_head.in_pre, fifo_head.out_pre);
          // in_pre/out_pre describe the last launched job, so an illegal
          // job leaves them untouched.
          if (pre_legal(fifo_head.in_pre, fifo_head.out_pre)) begin
            in_pre_d  = fifo_head.in_pre;
            out_pre_d = fifo_head.out_pre;
            cur_pre_d = fifo_head.in_pre;
          end
          state_d = ST_LAUNCH;
        end
      end
      // An illegal job also spends its pop cycle here with start
      // suppressed, so its completion appears one edge after the pop.
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = err_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = (cur_pre_q < out_pre_q) ? ST_MERGE : ST_DONE;
        end
      end
      ST_MERGE: begin
        cur_pre_d = cur_pre_q + 2'd1;
        if ((cur_pre_q + 2'd1) == out_pre_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start      = (state_q == ST_LAUNCH) && !err_q;
  assign align_ctl  = (state_q == ST_MERGE);
  assign merge_pre  = (state_q == ST_MERGE) ? cur_pre_q : 2'b00;
  assign busy       = (state_q != ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_tag   = (state_q == ST_DONE) ? tag_q : '0;
  assign done_err   = (state_q == ST_DONE) && err_q;
  assign in_pre     = in_pre_q;
  assign out_pre    = out_pre_q;

`ifdef FMA_SCHED_PERF_EN
  logic [15:0] perf_jobs_q, perf_merges_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs_q   <= '0;
      perf_merges_q <= '0;
    end else begin
      if (start && (perf_jobs_q != 16'hFFFF)) begin
        perf_jobs_q <= perf_jobs_q + 16'd1;
      end
      if (align_ctl && (perf_merges_q != 16'hFFFF)) begin
        perf_merges_q <= perf_merges_q + 16'd1;
      end
    end
  end

  assign perf_jobs   = perf_jobs_q;
  assign perf_merges = perf_merges_q;
`endif

endmodule

// File: tb/tb_fma_pass_sched.sv
// tb/tb_fma_pass_sched.sv - directed self-checking bench for fma_pass_sched
module tb_fma_pass_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_in_pre;
  logic [1:0] req_out_pre;
  logic [3:0] req_tag;
  logic       start;
  logic [1:0] in_pre;
  logic [1:0] out_pre;
  logic       align_ctl;
  logic [1:0] merge_pre;
  logic       busy;
  logic       done_valid;
  logic       done_ready;
  logic [3:0] done_tag;
  logic       done_err;
`ifdef FMA_SCHED_PERF_EN
  logic [15:0] perf_jobs;
  logic [15:0] perf_merges;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fma_pass_sched #(
    .PIPE_LAT   (4),
    .FIFO_DEPTH (4),
    .TAG_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in_pre  (req_in_pre),
    .req_out_pre (req_out_pre),
    .req_tag     (req_tag),
    .start       (start),
    .in_pre      (in_pre),
    .out_pre     (out_pre),
    .align_ctl   (align_ctl),
    .merge_pre   (merge_pre),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_tag    (done_tag),
    .done_err    (done_err)
`ifdef FMA_SCHED_PERF_EN
    ,
    .perf_jobs   (perf_jobs),
    .perf_merges (perf_merges)
`endif
  );

  function automatic logic [14:0] out_vec();
    return {start, align_ctl, merge_pre, busy, done_valid, done_tag, done_err, in_pre, out_pre};
  endfunction

  // Called #1 after a rising edge; the handshake edge is E0 and the task
  // returns #1 after it.
  task automatic push_job(input logic [1:0] ip, input logic [1:0] op, input logic [3:0] tg);
    req_valid   = 1'b1;
    req_in_pre  = ip;
    req_out_pre = op;
    req_tag     = tg;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Records activity for edges E1..E<ncyc>, sampled #1 after each edge.
  task automatic observe(input int ncyc, output int first_start, output int n_start,
                         output int n_align, output int first_done, output int n_done,
                         output logic [1:0] mp0, output logic [1:0] mp1,
                         output logic [3:0] dtag, output logic derr);
    first_start = -1; n_start = 0; n_align = 0; first_done = -1; n_done = 0;
    mp0 = 2'b11; mp1 = 2'b11; dtag = 4'h0; derr = 1'b0;
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge clk);
      #1;
      if (start) begin
        n_start++;
        if (first_start < 0) first_start = e;
      end
      if (align_ctl) begin
        if (n_align == 0) mp0 = merge_pre;
        else if (n_align == 1) mp1 = merge_pre;
        n_align++;
      end
      if (done_valid) begin
        if (first_done < 0) begin
          first_done = e;
          dtag = done_tag;
          derr = done_err;
        end
        n_done++;
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (out_vec() !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0000", out_vec());
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_merge();
    int fs, ns, na, fd, nd;
    logic [1:0] m0, m1;
    logic [3:0] t;
    logic er;
    done_ready = 1'b1;
    push_job(2'b00, 2'b00, 4'd3);
    observe(10, fs, ns, na, fd, nd, m0, m1, t, er);
    vectors++; if (fs !== 1) begin miscompares++; $display("FAIL k0_start_edge: got %0d expected 1", fs); end
    vectors++; if (ns !== 1) begin miscompares++; $display("FAIL k0_start_cycles: got %0d expected 1", ns); end
    vectors++; if (na !== 0) begin miscompares++; $display("FAIL k0_align_cycles: got %0d expected 0", na); end
    vectors++; if (fd !== 6) begin miscompares++; $display("FAIL k0_done_edge: got %0d expected 6", fd); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL k0_done_cycles: got %0d expected 1", nd); end
    vectors++; if (t !== 4'd3) begin miscompares++; $display("FAIL k0_done_tag: got %0d expected 3", t); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL k0_done_err: got %b expected 0", er); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL k0_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_two_merges();
    int fs, ns, na, fd, nd;
    logic [1:0] m0, m1;
    logic [3:0] t;
    logic er;
    done_ready = 1'b1;
    push_job(2'b00, 2'b10, 4'd5);
    observe(12, fs, ns, na, fd, nd, m0, m1, t, er);
    vectors++; if (fs !== 1) begin miscompares++; $display("FAIL k2_start_edge: got %0d expected 1", fs); end
    vectors++; if (na !== 2) begin miscompares++; $display("FAIL k2_align_cycles: got %0d expected 2", na); end
    vectors++; if (m0 !== 2'b00) begin miscompares++; $display("FAIL k2_merge_pre0: got %b expected 00", m0); end
    vectors++; if (m1 !== 2'b01) begin miscompares++; $display("FAIL k2_merge_pre1: got %b expected 01", m1); end
    vectors++; if (fd !== 8) begin miscompares++; $display("FAIL k2_done_edge: got %0d expected 8", fd); end
    vectors++; if (t !== 4'd5) begin miscompares++; $display("FAIL k2_done_tag: got %0d expected 5", t); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL k2_done_err: got %b expected 0", er); end
    vectors++; if ({in_pre, out_pre} !== 4'b0010) begin miscompares++; $display("FAIL k2_pre_held: got %b expected 0010", {in_pre, out_pre}); end
  endtask

  task automatic test_illegal();
    int fs, ns, na, fd, nd;
    logic [1:0] m0, m1;
    logic [3:0] t;
    logic er;
    logic [1:0] bad_out [2];
    bad_out[0] = 2'b01;
    bad_out[1] = 2'b11;
    done_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_job(2'b10, bad_out[i], 4'(9 + i));
      observe(6, fs, ns, na, fd, nd, m0, m1, t, er);
      vectors++; if (ns !== 0) begin miscompares++; $display("FAIL illegal%0d_start: got %0d expected 0", i, ns); end
      vectors++; if (fd !== 2) begin miscompares++; $display("FAIL illegal%0d_done_edge: got %0d expected 2", i, fd); end
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL illegal%0d_done_err: got %b expected 1", i, er); end
      vectors++; if (t !== 4'(9 + i)) begin miscompares++; $display("FAIL illegal%0d_done_tag: got %0d expected %0d", i, t, 9 + i); end
      vectors++; if ({in_pre, out_pre} !== 4'b0010) begin miscompares++; $display("FAIL illegal%0d_pre_held: got %b expected 0010", i, {in_pre, out_pre}); end
    end
  endtask

  task automatic test_queue_full();
    logic [3:0] exp_tags [5];
    logic [3:0] got_tags [5];
    int got;
    exp_tags[0] = 4'hA; exp_tags[1] = 4'd1; exp_tags[2] = 4'd2; exp_tags[3] = 4'd3; exp_tags[4] = 4'd4;
    for (int i = 0; i < 5; i++) got_tags[i] = 4'h0;
    done_ready = 1'b0;
    push_job(2'b00, 2'b00, 4'hA);
    repeat (8) @(posedge clk);
    #1;
    vectors++; if (done_valid !== 1'b1) begin miscompares++; $display("FAIL stall_in_done: got %b expected 1", done_valid); end
    for (int i = 0; i < 5; i++) begin
      req_valid   = 1'b1;
      req_in_pre  = 2'b00;
      req_out_pre = 2'b00;
      req_tag     = 4'(i + 1);
      vectors++;
      if (req_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL fill_req_ready%0d: got %b expected %b", i, req_ready, (i < 4));
      end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    done_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 120 && got < 5; c++) begin
      if (done_valid) begin
        got_tags[got] = done_tag;
        got++;
      end
      @(posedge clk);
      #1;
    end
    vectors++; if (got !== 5) begin miscompares++; $display("FAIL drain_count: got %0d expected 5", got); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got_tags[i] !== exp_tags[i]) begin
        miscompares++;
        $display("FAIL drain_order%0d: got %h expected %h", i, got_tags[i], exp_tags[i]);
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_merge();
    int n_done;
    done_ready = 1'b1;
    push_job(2'b00, 2'b10, 4'd7);
    push_job(2'b00, 2'b01, 4'd8);
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (align_ctl !== 1'b1) begin miscompares++; $display("FAIL midrst_in_merge: got %b expected 1", align_ctl); end
    rst_n = 1'b0;
    #1;
    vectors++; if (out_vec() !== 15'd0) begin miscompares++; $display("FAIL midrst_outputs: got %h expected 0000", out_vec()); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_req_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done_valid || start) n_done++;
    end
    vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL midrst_no_completion: got %0d expected 0", n_done); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_after: got %b expected 1", req_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_after: got %b expected 0", busy); end
  endtask

`ifdef FMA_SCHED_PERF_EN
  task automatic test_perf();
    int fs, ns, na, fd, nd;
    logic [1:0] m0, m1;
    logic [3:0] t;
    logic er;
    rst_n = 1'b0;
    #2;
    vectors++; if ({perf_jobs, perf_merges} !== 32'd0) begin miscompares++; $display("FAIL perf_reset: got %h expected 0", {perf_jobs, perf_merges}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b1;
    push_job(2'b00, 2'b00, 4'd1);
    observe(10, fs, ns, na, fd, nd, m0, m1, t, er);
    push_job(2'b00, 2'b01, 4'd2);
    observe(11, fs, ns, na, fd, nd, m0, m1, t, er);
    push_job(2'b00, 2'b10, 4'd3);
    observe(12, fs, ns, na, fd, nd, m0, m1, t, er);
    push_job(2'b11, 2'b00, 4'd4);
    observe(6, fs, ns, na, fd, nd, m0, m1, t, er);
    vectors++; if (perf_jobs !== 16'd3) begin miscompares++; $display("FAIL perf_jobs: got %0d expected 3", perf_jobs); end
    vectors++; if (perf_merges !== 16'd3) begin miscompares++; $display("FAIL perf_merges: got %0d expected 3", perf_merges); end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_in_pre  = 2'b00;
    req_out_pre = 2'b00;
    req_tag     = 4'h0;
    done_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_no_merge();
    test_two_merges();
    test_illegal();
    test_queue_full();
    test_reset_mid_merge();
`ifdef FMA_SCHED_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule
